// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits; one level per baud_tick.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 full,
    output logic                 overflow,
    output logic                 tx,
    output logic                 busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       LAST_BIT_C  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST_C = 1'(STOP_BITS - 1);
    localparam logic [1:0]       PARITY_C    = 2'(PARITY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even mode sends the XOR of the data bits, odd mode its inverse.
    function automatic logic parity_calc(input logic [DATA_BITS-1:0] word);
        return (^word) ^ (PARITY_C == 2'd2);
    endfunction

    state_t                 state_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   parity_r;
    logic [3:0]             bit_cnt_r;
    logic                   stop_cnt_r;
    logic                   tx_r;
    logic                   overflow_r;
    logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   frame_end_s;
    logic [DATA_BITS-1:0]   head_s;

    assign full_s      = (count_r == DEPTH_C);
    assign push_s      = wr_en && !full_s;
    assign frame_end_s = (state_r == ST_STOP) && (stop_cnt_r == STOP_LAST_C);
    // A pop only happens at a frame boundary, so a full FIFO still rejects a same-clk write.
    assign pop_s       = baud_tick && (count_r != {CNT_W{1'b0}})
                         && ((state_r == ST_IDLE) || frame_end_s);
    assign head_s      = mem_r[rd_ptr_r];

    assign full     = full_s;
    assign busy     = (state_r != ST_IDLE) || (count_r != {CNT_W{1'b0}});
    assign tx       = tx_r;
    assign overflow = overflow_r;

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers, occupancy and overflow strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= wr_en && full_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer; tx always shows the level for the interval just begun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            bit_cnt_r  <= 4'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
        end else if (baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r  <= head_s;
                        parity_r <= parity_calc(head_s);
                        tx_r     <= 1'b0;
                        state_r  <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    tx_r      <= shift_r[0];
                    shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_cnt_r <= 4'd0;
                    state_r   <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt_r != LAST_BIT_C) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else if (PARITY_C != 2'd0) begin
                        tx_r    <= parity_r;
                        state_r <= ST_PARITY;
                    end else begin
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_r       <= 1'b1;
                    stop_cnt_r <= 1'b0;
                    state_r    <= ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt_r != STOP_LAST_C) begin
                        stop_cnt_r <= stop_cnt_r + 1'b1;
                        tx_r       <= 1'b1;
                    end else if (pop_s) begin
                        shift_r  <= head_s;
                        parity_r <= parity_calc(head_s);
                        tx_r     <= 1'b0;
                        state_r  <= ST_START;
                    end else begin
                        tx_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations side by side, checked against a
// frame-level model (queue of words -> list of line levels per tick).
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] data_in = 9'd0;
    logic [2:0] tx_w, busy_w, full_w, ovf_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_param u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en),
        .data_in(data_in[7:0]), .full(full_w[0]), .overflow(ovf_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0])
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en),
        .data_in(data_in[6:0]), .full(full_w[1]), .overflow(ovf_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1])
    );

    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en),
        .data_in(data_in[7:0]), .full(full_w[2]), .overflow(ovf_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2])
    );

    // Reference model state, one slot per instance.
    int   f_mem [3][16];
    int   f_rd  [3];
    int   f_cnt [3];
    logic b_mem [3][16];
    int   b_len [3];
    int   b_pos [3];
    logic tx_m  [3];
    logic act_m [3];
    logic ovf_m [3];

    function automatic int cfg_db(input int k);
        return (k == 1) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int k);
        if (k == 1) return 1;
        if (k == 2) return 2;
        return 0;
    endfunction

    function automatic int cfg_sb(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            f_rd[k] = 0; f_cnt[k] = 0; b_len[k] = 0; b_pos[k] = 0;
            tx_m[k] = 1'b1; act_m[k] = 1'b0; ovf_m[k] = 1'b0;
        end
    endtask

    // Expand a word into the list of line levels it occupies.
    task automatic model_load(input int k, input int word);
        int n;
        int ones;
        int b;
        n = 0; ones = 0;
        b_mem[k][n] = 1'b0; n = n + 1;
        for (int i = 0; i < cfg_db(k); i++) begin
            b = (word >> i) & 1;
            ones = ones + b;
            b_mem[k][n] = (b == 1); n = n + 1;
        end
        if (cfg_par(k) != 0) begin
            b_mem[k][n] = ((ones % 2) == 1) ^ (cfg_par(k) == 2); n = n + 1;
        end
        for (int i = 0; i < cfg_sb(k); i++) begin
            b_mem[k][n] = 1'b1; n = n + 1;
        end
        b_len[k] = n;
        b_pos[k] = 0;
    endtask

    task automatic model_edge(input logic we, input int d, input logic tick);
        logic full_pre;
        int   word;
        for (int k = 0; k < 3; k++) begin
            full_pre = (f_cnt[k] == 4);
            word = d & ((1 << cfg_db(k)) - 1);
            if (tick) begin
                if (b_pos[k] < b_len[k]) begin
                    tx_m[k] = b_mem[k][b_pos[k]];
                    b_pos[k] = b_pos[k] + 1;
                end else if (f_cnt[k] > 0) begin
                    model_load(k, f_mem[k][f_rd[k]]);
                    f_rd[k] = (f_rd[k] + 1) % 16;
                    f_cnt[k] = f_cnt[k] - 1;
                    tx_m[k] = b_mem[k][0];
                    b_pos[k] = 1;
                    act_m[k] = 1'b1;
                end else begin
                    tx_m[k] = 1'b1;
                    act_m[k] = 1'b0;
                end
            end
            if (we && !full_pre) begin
                f_mem[k][(f_rd[k] + f_cnt[k]) % 16] = word;
                f_cnt[k] = f_cnt[k] + 1;
            end
            ovf_m[k] = we && full_pre;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("tx%0d", k), tx_w[k], tx_m[k]);
            chk($sformatf("busy%0d", k), busy_w[k], act_m[k] || (f_cnt[k] > 0));
            chk($sformatf("full%0d", k), full_w[k], f_cnt[k] == 4);
            chk($sformatf("overflow%0d", k), ovf_w[k], ovf_m[k]);
        end
    endtask

    task automatic cycle(input logic we, input int d, input logic tick);
        wr_en = we;
        data_in = d[8:0];
        baud_tick = tick;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(we, d, tick);
        #1;
        check_all();
        wr_en = 1'b0;
        baud_tick = 1'b0;
    endtask

    // One bit-period: tick (optionally with a write) then n-1 quiet clocks.
    task automatic interval(input int n, input logic we, input int d);
        cycle(we, d, 1'b1);
        for (int i = 1; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    logic [9:0]  seq_a5;
    logic [10:0] seq_55;

    initial begin
        seq_a5 = 10'b1101001010;
        seq_55 = 11'b11010101010;
        model_reset();

        // Reset state without any clock edge.
        #1 rst = 1'b0;
        #1 check_all();
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);
        rst = 1'b1;

        // Default frame of 0xA5 with 16-clk bit periods.
        cycle(1'b1, 'hA5, 1'b0);
        for (int i = 0; i < 13; i++) begin
            interval(16, 1'b0, 0);
            if (i < 10) chk("a5_seq", tx_w[0], seq_a5[i]);
            if (i == 10) chk("a5_idle_busy", busy_w[0], 1'b0);
        end

        // 7 data bits, even parity, 2 stop bits.
        cycle(1'b1, 'h55, 1'b0);
        for (int i = 0; i < 13; i++) begin
            interval(4, 1'b0, 0);
            if (i < 11) chk("d7e2_seq", tx_w[1], seq_55[i]);
        end

        // Odd parity bit for 0x01 and 0x00.
        cycle(1'b1, 'h01, 1'b0);
        for (int i = 0; i < 13; i++) begin
            interval(4, 1'b0, 0);
            if (i == 9) chk("odd_par_01", tx_w[2], 1'b0);
        end
        cycle(1'b1, 'h00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            interval(4, 1'b0, 0);
            if (i == 9) chk("odd_par_00", tx_w[2], 1'b1);
        end

        // Fill to full, overflow on the fifth write.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 'h11 + i, 1'b0);
            if (i == 3) chk("full_after_4", full_w[0], 1'b1);
            if (i == 4) chk("ovf_on_5th", ovf_w[0], 1'b1);
        end
        // Keep writing on every tick clk so writes collide with full-FIFO pops.
        for (int i = 0; i < 40; i++) interval(2, 1'b1, int'($urandom_range(0, 511)));
        for (int i = 0; i < 70; i++) interval(2, 1'b0, 0);

        // Randomised traffic with irregular tick spacing.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 511)), $urandom_range(0, 3) == 0);
        for (int i = 0; i < 80; i++) interval(2, 1'b0, 0);

        // Reset in the middle of the data phase with three words queued.
        cycle(1'b1, 'hF0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, int'($urandom_range(0, 511)), 1'b0);
        for (int i = 0; i < 4; i++) interval(2, 1'b0, 0);
        #3 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k), tx_w[k], 1'b1);
            chk($sformatf("rst_busy%0d", k), busy_w[k], 1'b0);
            chk($sformatf("rst_full%0d", k), full_w[k], 1'b0);
        end
        model_reset();
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) interval(2, 1'b0, 0);
        chk("post_rst_busy", busy_w[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
